lsu_store_router: RTL and testbench
===================================

// Module: lsu_store_router
// PURPOSE
//  Write-side counterpart of the LSU load-return mux. Takes one store per cycle from the core
//  and formats it into byte lanes: data replicated per lane, plus a byte mask.
//  Steers it by address to data memory or the peripheral/tohost window (addr[15:12] != 0).
//  Memory stores complete in the same cycle. Peripheral stores queue in a small FIFO that
//  drains over a valid/ready handshake; the core stalls only when that FIFO cannot accept.
// PARAMETERS
//  DEPTH      4   peripheral store FIFO entries; power of two, >= 2
//  ERR_W      8   width of saturating misaligned-store counter
// PORTS
//  clk          in   1      core clock; all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  st_valid     in   1      store request this cycle
//  st_addr      in   32     byte address
//  st_wdata     in   32     store data, LSB-aligned
//  st_size      in   2      00 byte, 01 half, 10 word (funct3[1:0]); 11 illegal
//  st_stall     out  1      peripheral store not accepted; core holds request, PC frozen
//  dmem_we      out  1      data-memory write strobe
//  dmem_addr    out  32     st_addr passed through
//  dmem_wdata   out  32     lane-replicated data
//  dmem_wmask   out  4      byte enables
//  per_valid    out  1      FIFO head valid
//  per_ready    in   1      peripheral accepts head
//  per_addr     out  32     head address
//  per_wdata    out  32     head lane-replicated data
//  per_wmask    out  4      head byte enables
//  per_pending  out  1      FIFO non-empty; load mux must not trust peripheral read-back
//  misalign     out  1      registered 1-cycle pulse: illegal or misaligned store dropped
//  misalign_cnt out  ERR_W  saturating count of dropped stores
// BEHAVIOUR
//  - Reset values: FIFO empty, per_valid=0, per_pending=0, misalign=0, misalign_cnt=0.
//    dmem_* are combinational, so they are 0 while st_valid=0.
//  - Lane formatting:
//    * byte: data={4{d[7:0]}}, mask=4'b0001<<addr[1:0].
//    * half: data={2{d[15:0]}}, mask=4'b0011<<{addr[1],1'b0}.
//    * word: data=d, mask=4'hF.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    No write to either target, no stall, misalign=1 next cycle, misalign_cnt+1 saturating at all-ones.
//  - Peripheral window: pw = |st_addr[15:12]. Applied to aligned stores only.
//  - Memory store (!pw): dmem_we=st_valid, zero latency. The FIFO is untouched.
//  - Peripheral store (pw): push when st_valid & (!full | pop).
//    * pop = per_valid & per_ready.
//    * st_stall = st_valid & pw & aligned & full & !pop. This is combinational.
//    * The pushed entry is visible at per_valid on the next cycle, never the same cycle.
//  - Simultaneous push and pop: when full, the occupancy is unchanged and the push succeeds.
//    When empty, the push lands and the pop is a no-op (per_valid was 0).
//  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    full = MSBs differ and the rest are equal; empty = pointers equal.
//  - Ordering: per_* drains in strict push order. Memory stores may overtake queued peripheral stores.
//  - Handshake: the head stays stable while per_valid & !per_ready.
//  - Reset mid-operation (rst_n low at any time) discards the queued entries immediately.
//    Any transfer in flight is lost.
// STRUCTURE
//  - Package lsu_pkg holds the following, also used by the load mux:
//    * typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} st_size_e
//    * localparam PERIPH_MASK = 32'h0000_F000
//    * typedef struct packed {addr; wdata; wmask} per_req_t
//  - One sub-module: sync_fifo #(.T(per_req_t), .DEPTH) with push/pop/full/empty/head.
//  - Lane formatting is a function in lsu_pkg.
// TESTING
//  1. sb 0xAB to 0x0000_0102
//     -> dmem_we=1, wmask=0100, wdata=ABABABAB; per_valid stays 0.
//  2. sh 0x1234 to 0x0000_0006
//     -> wmask=1100, wdata=12341234.
//  3. sw to 0x0000_0102
//     -> no writes, misalign=1 next cycle, misalign_cnt=1.
//     After 260 such stores, the count holds at 0xFF.
//  4. sw 0x1 to 0x0000_1000 with per_ready=0
//     -> per_valid=1 next cycle, head is addr 0x1000 / mask F.
//     After 4 pushes st_stall=1; the 5th store holds.
//     Raise per_ready one cycle -> pop+push, st_stall=0 that cycle, occupancy stays 4.
//  5. Queue 3 peripheral stores, then one dmem store
//     -> dmem write the same cycle; per drain order is unchanged.
//  6. rst_n low for one cycle with 3 queued entries
//     -> per_valid=0 and per_pending=0 immediately, misalign_cnt=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types and store lane formatting helpers (also used by the load mux).
// Latency: none, package only.
// Backpressure: not applicable.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} st_size_e;

    // Any address bit in this window selects the peripheral/tohost target
    localparam logic [31:0] PERIPH_MASK = 32'h0000_F000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } per_req_t;

    // True when the access size is legal and naturally aligned
    function automatic logic st_aligned(input st_size_e sz, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~a[0];
            SZ_W:    ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate data across byte lanes and build the matching byte mask
    function automatic per_req_t fmt_store(input logic [31:0] addr,
                                           input logic [31:0] d,
                                           input st_size_e    sz);
        per_req_t r;
        r.addr  = addr;
        r.wdata = d;
        r.wmask = 4'hF;
        case (sz)
            SZ_B: begin
                r.wdata = {4{d[7:0]}};
                r.wmask = 4'b0001 << addr[1:0];
            end
            SZ_H: begin
                r.wdata = {2{d[15:0]}};
                r.wmask = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                r.wdata = d;
                r.wmask = 4'hF;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers.
// Latency: a pushed entry appears at head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    T            mem_q [DEPTH];
    logic        do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    // Next-state pointers; an extra wrap bit separates full from empty
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    // Pointer registers; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; when full, push+pop writes the slot being vacated by the head
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lsu_store_router.sv
// Formats core stores into byte lanes and steers them to dmem or a peripheral queue.
// Latency: dmem writes combinational (0 cycles); peripheral head visible 1 cycle after push.
// Backpressure: st_stall only when the peripheral queue is full and its head is not popping.
module lsu_store_router
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_wdata,
    input  logic [1:0]       st_size,
    output logic             st_stall,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_wmask,
    output logic             per_valid,
    input  logic             per_ready,
    output logic [31:0]      per_addr,
    output logic [31:0]      per_wdata,
    output logic [3:0]       per_wmask,
    output logic             per_pending,
    output logic             misalign,
    output logic [ERR_W-1:0] misalign_cnt
);

    st_size_e   sz;
    per_req_t   req, head;
    logic       aligned, pw, full, empty, pop, push;
    logic       misalign_q, misalign_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    assign sz      = st_size_e'(st_size);
    assign aligned = st_aligned(sz, st_addr[1:0]);
    assign pw      = |(st_addr & PERIPH_MASK);
    assign req     = fmt_store(st_addr, st_wdata, sz);

    // Memory path: zero latency, outputs forced to zero when not writing
    assign dmem_we    = st_valid & aligned & ~pw;
    assign dmem_addr  = dmem_we ? req.addr  : 32'h0;
    assign dmem_wdata = dmem_we ? req.wdata : 32'h0;
    assign dmem_wmask = dmem_we ? req.wmask : 4'h0;

    // Peripheral path: a pop frees the slot the same cycle so a full queue still accepts
    assign pop      = per_valid & per_ready;
    assign push     = st_valid & aligned & pw & (~full | pop);
    assign st_stall = st_valid & aligned & pw & full & ~pop;

    sync_fifo #(.T(per_req_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign per_valid   = ~empty;
    assign per_pending = ~empty;
    assign per_addr    = head.addr;
    assign per_wdata   = head.wdata;
    assign per_wmask   = head.wmask;

    // Dropped-store pulse and saturating counter next state
    always_comb begin
        misalign_d = st_valid & ~aligned;
        cnt_d      = cnt_q;
        if (misalign_d && !(&cnt_q)) cnt_d = cnt_q + ERR_W'(1);
    end

    // Error reporting registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign misalign     = misalign_q;
    assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_lsu_store_router.sv
// Scoreboard bench for lsu_store_router: directed stores, monitor-side checking.
// Latency: n/a.
// Backpressure: per_ready driven by the stimulus process.
module tb_lsu_store_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr, st_wdata;
    logic [1:0]  st_size;
    logic        st_stall, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        per_valid, per_ready;
    logic [31:0] per_addr, per_wdata;
    logic [3:0]  per_wmask;
    logic        per_pending, misalign;
    logic [7:0]  misalign_cnt;

    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;

    logic [67:0] dmem_q[$];
    logic [67:0] per_q[$];

    // misalign pulse / count reference
    logic       mis_next = 1'b0;
    logic       mis_exp;
    logic [7:0] cnt_exp;

    always #5 clk = ~clk;

    lsu_store_router #(.DEPTH(4), .ERR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .st_size      (st_size),
        .st_stall     (st_stall),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .per_valid    (per_valid),
        .per_ready    (per_ready),
        .per_addr     (per_addr),
        .per_wdata    (per_wdata),
        .per_wmask    (per_wmask),
        .per_pending  (per_pending),
        .misalign     (misalign),
        .misalign_cnt (misalign_cnt)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_exp <= 1'b0;
            cnt_exp <= 8'h00;
        end else begin
            mis_exp <= mis_next;
            if (mis_next && cnt_exp != 8'hFF) cnt_exp <= cnt_exp + 8'h01;
        end
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every DUT write against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dmem_we) begin
                if (dmem_q.size() == 0) chk("dmem_unexpected", {dmem_addr, dmem_wdata, dmem_wmask}, 68'h0);
                else chk("dmem_write", {dmem_addr, dmem_wdata, dmem_wmask}, dmem_q.pop_front());
            end
            if (per_valid && per_ready) begin
                pop_cnt++;
                if (per_q.size() == 0) chk("per_unexpected", {per_addr, per_wdata, per_wmask}, 68'h0);
                else chk("per_write", {per_addr, per_wdata, per_wmask}, per_q.pop_front());
            end
            chk("misalign_pulse", 68'(misalign), 68'(mis_exp));
        end
    end

    // kind: 0 memory store, 1 peripheral store, 2 dropped store
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input int kind, input logic [31:0] ed, input logic [3:0] em);
        @(posedge clk); #1;
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_size  = sz;
        mis_next = (kind == 2);
        if (kind == 0) dmem_q.push_back({a, ed, em});
        if (kind == 1) per_q.push_back({a, ed, em});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_wdata = 32'h0;
        st_size  = 2'b00;
        mis_next = 1'b0;
    endtask

    task automatic drain(input string name, input int exp_pops);
        int start;
        start = pop_cnt;
        @(posedge clk); #1;
        per_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!per_valid) break;
        end
        chk({name, "_drained"}, 68'(per_valid), 68'h0);
        chk({name, "_pops"}, 68'(pop_cnt - start), 68'(exp_pops));
        @(posedge clk); #1;
        per_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = 32'h0; st_wdata = 32'h0; st_size = 2'b00;
        per_ready = 1'b0;
        #12;
        chk("rst_per_valid", 68'(per_valid), 68'h0);
        chk("rst_per_pending", 68'(per_pending), 68'h0);
        chk("rst_misalign", 68'(misalign), 68'h0);
        chk("rst_misalign_cnt", 68'(misalign_cnt), 68'h0);
        chk("rst_dmem", {dmem_we, dmem_addr, dmem_wdata, dmem_wmask}, 68'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane formatting to data memory
        drive(32'h0000_0102, 32'h0000_00AB, 2'b00, 0, 32'hABAB_ABAB, 4'b0100);
        drive(32'h0000_0006, 32'h0000_1234, 2'b01, 0, 32'h1234_1234, 4'b1100);
        drive(32'h0000_0003, 32'hFFFF_FFC3, 2'b00, 0, 32'hC3C3_C3C3, 4'b1000);
        drive(32'h0000_0004, 32'h7777_A55A, 2'b01, 0, 32'hA55A_A55A, 4'b0011);
        drive(32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF, 4'b1111);
        idle();
        @(negedge clk);
        chk("mem_no_per_valid", 68'(per_valid), 68'h0);
        chk("idle_dmem_zero", {dmem_we, dmem_addr, dmem_wdata, dmem_wmask}, 68'h0);

        // Dropped stores
        drive(32'h0000_0102, 32'h1, 2'b10, 2, 32'h0, 4'h0);
        idle();
        @(negedge clk);
        chk("misalign_cnt_one", 68'(misalign_cnt), 68'h1);
        drive(32'h0000_0101, 32'h1, 2'b01, 2, 32'h0, 4'h0);
        drive(32'h0000_0100, 32'h1, 2'b11, 2, 32'h0, 4'h0);
        drive(32'h0000_1102, 32'h1, 2'b10, 2, 32'h0, 4'h0);
        idle();
        @(negedge clk);
        chk("misalign_cnt_four", 68'(misalign_cnt), 68'h4);
        chk("misaligned_per_no_push", 68'(per_valid), 68'h0);
        for (int i = 0; i < 260; i++) drive(32'h0000_0102, 32'h1, 2'b10, 2, 32'h0, 4'h0);
        idle();
        @(negedge clk);
        chk("misalign_cnt_sat", 68'(misalign_cnt), 68'hFF);
        chk("misalign_cnt_model", 68'(misalign_cnt), 68'(cnt_exp));

        // Peripheral queue fill, stall and pop+push
        drive(32'h0000_1000, 32'h0000_0001, 2'b10, 1, 32'h0000_0001, 4'hF);
        @(negedge clk);
        chk("per_not_same_cycle", 68'(per_valid), 68'h0);
        drive(32'h0000_1004, 32'h0000_0002, 2'b10, 1, 32'h0000_0002, 4'hF);
        @(negedge clk);
        chk("per_head_first", {per_valid, per_addr, per_wmask}, {1'b1, 32'h0000_1000, 4'hF});
        drive(32'h0000_1008, 32'h0000_0003, 2'b10, 1, 32'h0000_0003, 4'hF);
        drive(32'h0000_100C, 32'h0000_0004, 2'b10, 1, 32'h0000_0004, 4'hF);
        @(negedge clk);
        chk("stall_before_full", 68'(st_stall), 68'h0);
        @(posedge clk); #1;
        st_addr = 32'h0000_1010; st_wdata = 32'h0000_0005; st_size = 2'b10; mis_next = 1'b0;
        @(negedge clk);
        chk("stall_full", 68'(st_stall), 68'h1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_held", 68'(st_stall), 68'h1);
        chk("stall_head_stable", {per_addr, per_wdata, per_wmask}, {32'h0000_1000, 32'h1, 4'hF});
        @(posedge clk); #1;
        per_ready = 1'b1;
        per_q.push_back({32'h0000_1010, 32'h0000_0005, 4'hF});
        @(negedge clk);
        chk("stall_release", 68'(st_stall), 68'h0);
        idle();
        per_ready = 1'b0;
        @(negedge clk);
        chk("full_after_poppush", 68'(per_pending), 68'h1);
        drain("occupancy4", 4);

        // Memory store overtakes queued peripheral stores
        drive(32'h0000_2000, 32'h0000_0011, 2'b00, 1, 32'h1111_1111, 4'b0001);
        drive(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1, 32'hBEEF_BEEF, 4'b1100);
        drive(32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1, 32'hCAFE_F00D, 4'hF);
        drive(32'h0000_0040, 32'h55AA_55AA, 2'b10, 0, 32'h55AA_55AA, 4'hF);
        idle();
        @(negedge clk);
        chk("dmem_overtake_done", 68'(dmem_q.size()), 68'h0);
        drain("order", 3);

        // Reset with queued entries
        drive(32'h0000_3000, 32'h1, 2'b10, 1, 32'h1, 4'hF);
        drive(32'h0000_3004, 32'h2, 2'b10, 1, 32'h2, 4'hF);
        drive(32'h0000_3008, 32'h3, 2'b10, 1, 32'h3, 4'hF);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        per_q.delete();
        #1;
        chk("midrst_per_valid", 68'(per_valid), 68'h0);
        chk("midrst_per_pending", 68'(per_pending), 68'h0);
        chk("midrst_cnt", 68'(misalign_cnt), 68'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(32'h0000_4000, 32'h0000_00A5, 2'b00, 1, 32'hA5A5_A5A5, 4'b0001);
        idle();
        drain("post_reset", 1);

        chk("dmem_q_empty", 68'(dmem_q.size()), 68'h0);
        chk("per_q_empty", 68'(per_q.size()), 68'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
